// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial RAM port arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;

    localparam logic [DATA_LEN-1:0] ZERO_WORD = '0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_IF_RD  = 2'b01,
        ST_MEM_RD = 2'b10,
        ST_MEM_WR = 2'b11
    } state_e;

    // mem_len encodings (2'b11 behaves like a word)
    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    // addr[17:16] value that marks the memory-mapped IO range
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    // Instruction fetches are always a full word
    localparam logic [2:0] IF_BYTES = 3'd4;

    // Number of byte transfers for a MEM access length code
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one byte-wide RAM port between instruction fetch and the
// MEM stage. Each request is serialised into byte transfers; reads are
// assembled little-endian, writes are split into bytes. MEM has priority.
// Optional build macro IO_STALL_EN adds io_buffer_full back-pressure for
// byte writes into the IO range (addr[17:16] == 2'b11), with one idle gap
// cycle after each IO byte.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN,
    parameter int DATA_W = DATA_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
`ifdef IO_STALL_EN
    input  logic              io_buffer_full,
`endif
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic              gap_q, gap_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic grant_mem;
    logic grant_if;
    logic rd_last;
    logic wr_last;
    logic stall;
    logic gap_take;

    // A requester is not re-granted while its own done pulse is still high
    assign grant_mem = (state_q == ST_IDLE) && mem_req && !mem_done_q;
    assign grant_if  = (state_q == ST_IDLE) && !grant_mem && if_req
                       && !if_flush && !if_done_q;

    // Read finishes on the edge that captures the last byte; write finishes
    // on the edge after the last byte was presented
    assign rd_last = (cnt_q == len_q);
    assign wr_last = (cnt_q == (len_q - 3'd1));

`ifdef IO_STALL_EN
    logic io_byte;
    assign io_byte  = (state_q == ST_MEM_WR) && !gap_q
                      && (ram_a_q[17:16] == IO_ADDR_HI);
    assign stall    = io_byte && io_buffer_full;
    assign gap_take = io_byte && !io_buffer_full;
`else
    assign stall    = 1'b0;
    assign gap_take = 1'b0;
`endif

    // State register; rdy=0 freezes the FSM
    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grant in IDLE, finish or abort in the busy states
    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_d = mem_we ? ST_MEM_WR : ST_MEM_RD;
                end else if (grant_if) begin
                    state_d = ST_IF_RD;
                end
            end
            ST_IF_RD: begin
                if (if_flush || rd_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_RD: begin
                if (rd_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_WR: begin
                if (!stall && !gap_take && wr_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath/output logic: address stepping, byte assembly and splitting
    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        gap_d       = gap_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        asm_d       = asm_q;
        wdata_d     = wdata_q;
        if_done_d   = DISABLE;
        mem_done_d  = DISABLE;

        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    cnt_d   = 3'd0;
                    len_d   = len_to_bytes(mem_len);
                    ram_a_d = mem_addr;
                    asm_d   = '0;
                    wdata_d = mem_wdata;
                    gap_d   = DISABLE;
                    if (mem_we) begin
                        ram_dout_d = mem_wdata[7:0];
                        ram_wr_d   = ENABLE;
                    end
                end else if (grant_if) begin
                    cnt_d   = 3'd0;
                    len_d   = IF_BYTES;
                    ram_a_d = if_addr;
                    asm_d   = '0;
                end
            end
            ST_IF_RD, ST_MEM_RD: begin
                // A flushed fetch is dropped without touching if_data
                if (!(state_q == ST_IF_RD && if_flush)) begin
                    cnt_d = cnt_q + 3'd1;
                    if ((cnt_q + 3'd1) < len_q) begin
                        ram_a_d = ram_a_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                    if (cnt_q != 3'd0) begin
                        asm_d[{cnt_q - 3'd1, 3'b000} +: 8] = ram_din;
                    end
                    if (rd_last) begin
                        if (state_q == ST_IF_RD) begin
                            if_data_d = asm_d;
                            if_done_d = ENABLE;
                        end else begin
                            mem_rdata_d = asm_d;
                            mem_done_d  = ENABLE;
                        end
                    end
                end
            end
            ST_MEM_WR: begin
                if (gap_take) begin
                    ram_wr_d = DISABLE;
                    gap_d    = ENABLE;
                end else if (!stall) begin
                    gap_d = DISABLE;
                    if (wr_last) begin
                        ram_wr_d   = DISABLE;
                        mem_done_d = ENABLE;
                    end else begin
                        cnt_d      = cnt_q + 3'd1;
                        ram_a_d    = ram_a_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        ram_dout_d = wdata_q[{cnt_q + 3'd1, 3'b000} +: 8];
                        ram_wr_d   = ENABLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; all hold while rdy=0, including pending done pulses
    // NOTE: data registers are reset too because they drive outputs that must read 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            len_q       <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= DISABLE;
            if_done_q   <= DISABLE;
            mem_done_q  <= DISABLE;
            gap_q       <= DISABLE;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            asm_q       <= '0;
            wdata_q     <= '0;
        end else if (rdy) begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            gap_q       <= gap_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            asm_q       <= asm_d;
            wdata_q     <= wdata_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q && rdy && !stall;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;

endmodule
